ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Sequencing controller for the EX stage of the 5-stage MIPS pipeline.
- Tracks in-flight destination registers through EX, MEM and WB.
- Drives the EX destination-register mux select (rt vs rd) and the ALU operand forwarding mux selects.
- Raises a one-cycle load-use stall and inserts a bubble into EX.

Parameters:
- REG_W, 5, register-specifier width; register 0 is hardwired zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  instruction in ID is real (not a bubble).
- id_rs  in  REG_W  source register rs of the ID instruction.
- id_rt  in  REG_W  source register rt of the ID instruction.
- id_rd  in  REG_W  rd field of the ID instruction.
- id_reg_dst  in  1  destination select: 0 = rt, 1 = rd.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  kill the ID instruction (taken branch/jump).
- ex_dst_sel  out  1  registered select for the EX 5-bit destination mux.
- ex_wreg  out  REG_W  resolved destination register of the EX instruction.
- fwd_a  out  2  operand A source: 00 = regfile, 10 = EX/MEM result, 01 = MEM/WB result.
- fwd_b  out  2  operand B source, same encoding as fwd_a.
- stall  out  1  hold PC and IF/ID this cycle.

Behaviour:
- Reset (asynchronous, immediate on rst high): all stage registers clear.
  - Outputs go to ex_dst_sel=0, ex_wreg=0, fwd_a=fwd_b=00, stall=0.
  - The pipeline holds bubbles until the first clock edge after rst falls.
- EX stage register, loaded every rising edge, holds: valid, rs, rt, wreg, dst_sel, reg_write, mem_read.
  - wreg = id_reg_dst ? id_rd : id_rt, resolved at load time (the same selection the EX mux performs).
- Bubble: if stall or flush or !id_valid, EX loads valid=0, reg_write=0, mem_read=0, wreg=0, dst_sel=0.
  - rs and rt load 0.
- MEM stage: loads {wreg, reg_write & valid} from EX every edge.
- WB stage: loads the same fields from MEM every edge. No stage ever holds; a stall only injects a bubble.
- ex_dst_sel and ex_wreg come straight from EX stage flops, with no combinational input path.
- Forwarding is combinational from stage flops only. Operand A:
  - fwd_a=10 if mem_reg_write & mem_wreg!=0 & mem_wreg==ex_rs.
  - Otherwise fwd_a=01 if wb_reg_write & wb_wreg!=0 & wb_wreg==ex_rs.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB when both match.
- Operand B: identical to operand A, using ex_rt.
- fwd_a and fwd_b are forced to 00 when ex valid=0.
- stall = id_valid & !flush & ex_valid & ex_mem_read & ex_wreg!=0 & (ex_wreg==id_rs | ex_wreg==id_rt).
  - Comparison is conservative: rt is compared even when the instruction does not read it.
- After a stall the load has moved to MEM. On the next cycle stall deasserts and the held instruction enters EX.
  - When that instruction reaches EX, the load is in WB and forwarding selects 01.
- flush and stall in the same cycle: flush wins. stall=0 and a bubble is inserted.
- Register 0 never stalls and never forwards.
- rst asserted mid-stall: stall drops immediately and all in-flight state is discarded.

Test Plan:
- Reset: rst=1 with random inputs, then release. Required: all outputs 0 and fwd 00 for 3 cycles of id_valid=0.
- RegDst path: issue id_rt=5, id_rd=9, id_reg_dst=1, then id_reg_dst=0. Required:
  - Cycle after first issue: ex_dst_sel=1, ex_wreg=9.
  - Next cycle: ex_dst_sel=0, ex_wreg=5.
- Forward priority: issue add writing $3, then add writing $3, then an instruction with rs=3 and rt=3. Required: at the third instruction in EX, fwd_a=10 and fwd_b=10.
  - Repeat with one unrelated instruction in between. Required: fwd_a=01.
- Load-use: issue lw writing $4 (mem_read=1, reg_dst=0, rt=4), then an instruction with rs=4. Required:
  - stall=1 for exactly one cycle, with EX valid=0 (bubble) on the next edge.
  - When the dependent instruction reaches EX: fwd_a=01.
- Zero register and flush: lw writing $0 followed by rs=0. Required: stall=0 and fwd 00.
  - lw $4 followed by a dependent instruction with flush=1. Required: stall=0 and a bubble in EX.
- Async reset mid-operation: assert rst between edges while stall=1. Required: stall=0 and ex_wreg=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: tracks EX/MEM/WB destinations, drives the destination mux select,
// the ALU operand forwarding selects, and the load-use stall.
// Latency: stage registers advance every cycle; fwd_* and stall are combinational from flops and ID fields.
// Backpressure: a load-use stall holds PC and IF/ID for one cycle while a bubble enters EX; no stage ever holds.
//
// Ports:
//   clk, rst                                   rising-edge clock, asynchronous active-high reset
//   id_valid, id_rs, id_rt, id_rd              ID instruction and its register fields
//   id_reg_dst, id_reg_write, id_mem_read      ID control bits (rt/rd select, regfile write, load)
//   flush                                      kill the ID instruction (taken branch/jump)
//   ex_dst_sel, ex_wreg                        registered EX destination select and resolved destination
//   fwd_a, fwd_b                               operand sources: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall                                      hold PC and IF/ID this cycle
module ex_hazard_ctrl #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             ex_dst_sel,
    output logic [REG_W-1:0] ex_wreg,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall
);

    // EX stage state (ex_dst_sel and ex_wreg are the output flops themselves)
    logic             ex_valid;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;

    // MEM and WB stage state
    logic [REG_W-1:0] mem_wreg;
    logic             mem_reg_write;
    logic [REG_W-1:0] wb_wreg;
    logic             wb_reg_write;

    logic             bubble;

    // Load-use check is conservative: rt is compared even if the ID instruction never reads it.
    // A flush kills the dependent instruction anyway, so it suppresses the stall.
    always_comb begin
        stall = id_valid & ~flush & ex_valid & ex_mem_read & (ex_wreg != '0) &
                ((ex_wreg == id_rs) | (ex_wreg == id_rt));
    end

    assign bubble = stall | flush | ~id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_wreg      <= '0;
            ex_dst_sel   <= 1'b0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_wreg      <= '0;
            ex_dst_sel   <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            // Resolve the destination now, matching what the EX rt/rd mux will select.
            ex_wreg      <= id_reg_dst ? id_rd : id_rt;
            ex_dst_sel   <= id_reg_dst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wreg      <= '0;
            mem_reg_write <= 1'b0;
            wb_wreg       <= '0;
            wb_reg_write  <= 1'b0;
        end else begin
            mem_wreg      <= ex_wreg;
            mem_reg_write <= ex_reg_write & ex_valid;
            wb_wreg       <= mem_wreg;
            wb_reg_write  <= mem_reg_write;
        end
    end

    // Forwarding: EX/MEM (newest value) wins over MEM/WB; register 0 never forwards.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_valid) begin
            if (mem_reg_write && (mem_wreg != '0) && (mem_wreg == ex_rs))
                fwd_a = 2'b10;
            else if (wb_reg_write && (wb_wreg != '0) && (wb_wreg == ex_rs))
                fwd_a = 2'b01;

            if (mem_reg_write && (mem_wreg != '0) && (mem_wreg == ex_rt))
                fwd_b = 2'b10;
            else if (wb_reg_write && (wb_wreg != '0) && (wb_wreg == ex_rt))
                fwd_b = 2'b01;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: reset, rt/rd destination select, forwarding priority,
// load-use stall and bubble, zero register, flush, and asynchronous reset during a stall.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_ex_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       id_reg_dst;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic       ex_dst_sel;
    logic [4:0] ex_wreg;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall;

    int total = 0;
    int bad   = 0;

    ex_hazard_ctrl #(.REG_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_reg_dst   (id_reg_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .ex_dst_sel   (ex_dst_sel),
        .ex_wreg      (ex_wreg),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic dst, input logic rw,
                          input logic mr, input logic fl);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_reg_dst   = dst;
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
    endtask

    // Advance one edge; inputs may change afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        repeat (3) @(posedge clk);
        #1;
        check("rst_wreg", 8'(ex_wreg), 8'd0);
        check("rst_stall", 8'(stall), 8'd0);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_outs", {ex_dst_sel, ex_wreg, stall},  8'd0);
            check("idle_fwd",  {4'd0, fwd_a, fwd_b},           8'd0);
        end

        // RegDst path
        set_id(1'b1, 5'd0, 5'd5, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("rd_dst_sel", 8'(ex_dst_sel), 8'd1);
        check("rd_wreg",    8'(ex_wreg),    8'd9);
        set_id(1'b1, 5'd0, 5'd5, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("rt_dst_sel", 8'(ex_dst_sel), 8'd0);
        check("rt_wreg",    8'(ex_wreg),    8'd5);
        idle(3);

        // Forward priority: two writers of $3 back to back, then a reader of $3 on both operands
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd3, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("prio_nostall", 8'(stall), 8'd0);
        tick();
        check("prio_fwd_a", 8'(fwd_a), 8'b10);
        check("prio_fwd_b", 8'(fwd_b), 8'b10);
        idle(3);

        // Same, with an unrelated instruction in between: MEM/WB source
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd3, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("wb_fwd_a", 8'(fwd_a), 8'b01);
        check("wb_fwd_b", 8'(fwd_b), 8'b01);
        idle(3);

        // Load-use: lw $4, then a reader of $4 in rs
        set_id(1'b1, 5'd1, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("lu_stall", 8'(stall), 8'd1);
        tick();
        check("lu_bubble", {ex_dst_sel, ex_wreg}, 8'd0);
        check("lu_fwd_bubble", {4'd0, fwd_a, fwd_b}, 8'd0);
        check("lu_stall_once", 8'(stall), 8'd0);
        tick();
        check("lu_dep_wreg", 8'(ex_wreg), 8'd6);
        check("lu_fwd_a",    8'(fwd_a),   8'b01);
        check("lu_fwd_b",    8'(fwd_b),   8'b00);
        idle(3);

        // Zero register: lw $0 then a reader of $0
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("zero_stall", 8'(stall), 8'd0);
        tick();
        check("zero_wreg", 8'(ex_wreg), 8'd6);
        check("zero_fwd",  {4'd0, fwd_a, fwd_b}, 8'd0);
        idle(3);

        // Flush beats load-use stall
        set_id(1'b1, 5'd1, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        check("flush_stall", 8'(stall), 8'd0);
        tick();
        check("flush_bubble", {ex_dst_sel, ex_wreg}, 8'd0);
        check("flush_fwd",    {4'd0, fwd_a, fwd_b},  8'd0);
        idle(3);

        // Asynchronous reset while stalled
        set_id(1'b1, 5'd1, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd2, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("ar_pre_stall", 8'(stall),   8'd1);
        check("ar_pre_wreg",  8'(ex_wreg), 8'd4);
        #2;
        rst = 1'b1;
        #1;
        check("ar_stall", 8'(stall),   8'd0);
        check("ar_wreg",  8'(ex_wreg), 8'd0);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check("ar_after", {ex_dst_sel, ex_wreg, stall}, 8'd0);
        check("ar_after_fwd", {4'd0, fwd_a, fwd_b}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
